// File: rtl/det_seq.sv
// Sequential signed determinant unit for 2x2 / 3x3 matrices.
// One shared multiplier, time-multiplexed over a row-0 cofactor expansion, with a saturated result.
module det_seq #(
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [9*DW-1:0]    mat,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OW-1:0]      det,
    output logic               ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int MW = 2*DW + 1;   // minor width
    localparam int AW = 3*DW + 1;   // exact accumulator width

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    typedef enum logic [1:0] {OP_MIN_SET, OP_MIN_SUB, OP_ACC_ADD, OP_ACC_SUB} op_t;

    state_t state, state_nxt;

    logic [9*DW-1:0]        mat_q;
    logic                   mode_q;
    logic [3:0]             step;
    logic signed [MW-1:0]   minor;
    logic signed [AW-1:0]   acc;

    logic signed [DW-1:0]   op_a;
    logic signed [MW-1:0]   op_b;
    op_t                    op;
    logic signed [AW-1:0]   prod;
    logic                   accept;
    logic                   steps_done;
    logic                   finish;

    function automatic logic signed [DW-1:0] el(input logic [9*DW-1:0] m, input int r, input int c);
        return $signed(m[(3*r+c)*DW +: DW]);
    endfunction

    function automatic logic signed [MW-1:0] sx(input logic signed [DW-1:0] v);
        return MW'(v);
    endfunction

    assign accept     = (state == IDLE) && in_valid;
    assign steps_done = (step == (mode_q ? 4'd9 : 4'd2));
    assign finish     = (state == COMPUTE) && steps_done;

    // Operand schedule: 3x3 runs minor(2 steps) then term(1 step) for each column of row 0.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op   = OP_ACC_ADD;
        if (!mode_q) begin
            case (step)
                4'd0:    begin op_a = el(mat_q, 0, 0); op_b = sx(el(mat_q, 1, 1)); op = OP_ACC_ADD; end
                4'd1:    begin op_a = el(mat_q, 0, 1); op_b = sx(el(mat_q, 1, 0)); op = OP_ACC_SUB; end
                default: ;
            endcase
        end else begin
            case (step)
                4'd0:    begin op_a = el(mat_q, 1, 1); op_b = sx(el(mat_q, 2, 2)); op = OP_MIN_SET; end
                4'd1:    begin op_a = el(mat_q, 1, 2); op_b = sx(el(mat_q, 2, 1)); op = OP_MIN_SUB; end
                4'd2:    begin op_a = el(mat_q, 0, 0); op_b = minor;               op = OP_ACC_ADD; end
                4'd3:    begin op_a = el(mat_q, 1, 0); op_b = sx(el(mat_q, 2, 2)); op = OP_MIN_SET; end
                4'd4:    begin op_a = el(mat_q, 1, 2); op_b = sx(el(mat_q, 2, 0)); op = OP_MIN_SUB; end
                4'd5:    begin op_a = el(mat_q, 0, 1); op_b = minor;               op = OP_ACC_SUB; end
                4'd6:    begin op_a = el(mat_q, 1, 0); op_b = sx(el(mat_q, 2, 1)); op = OP_MIN_SET; end
                4'd7:    begin op_a = el(mat_q, 1, 1); op_b = sx(el(mat_q, 2, 0)); op = OP_MIN_SUB; end
                4'd8:    begin op_a = el(mat_q, 0, 2); op_b = minor;               op = OP_ACC_ADD; end
                default: ;
            endcase
        end
    end

    assign prod = AW'(op_a) * AW'(op_b);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (steps_done) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: operand/working registers carry no reset; they are always reloaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            mat_q  <= mat;
            mode_q <= mode;
            acc    <= '0;
            minor  <= '0;
            step   <= '0;
        end else if (state == COMPUTE && !steps_done) begin
            step <= step + 4'd1;
            case (op)
                OP_MIN_SET: minor <= prod[MW-1:0];
                OP_MIN_SUB: minor <= minor - prod[MW-1:0];
                OP_ACC_ADD: acc   <= acc + prod;
                OP_ACC_SUB: acc   <= acc - prod;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det <= '0;
            ovf <= 1'b0;
        end else if (finish) begin
            if (acc > SAT_MAX) begin
                det <= SAT_MAX[OW-1:0];
                ovf <= 1'b1;
            end else if (acc < SAT_MIN) begin
                det <= SAT_MIN[OW-1:0];
                ovf <= 1'b1;
            end else begin
                det <= acc[OW-1:0];
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_det_seq.sv
// Directed self-checking bench for det_seq: 2x2, 3x3, saturation, backpressure,
// mid-operation reset and back-to-back requests.
module tb_det_seq;

    localparam int DW = 8;
    localparam int OW = 16;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [9*DW-1:0]   mat;
    logic              in_valid;
    logic              in_ready;
    logic [OW-1:0]     det;
    logic              ovf;
    logic              out_valid;
    logic              out_ready;

    int n_checks = 0;
    int n_errors = 0;

    det_seq #(.DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .mat       (mat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .det       (det),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9*DW-1:0] pack(input int e[9]);
        logic [9*DW-1:0] m;
        for (int i = 0; i < 9; i++) m[i*DW +: DW] = DW'(e[i]);
        return m;
    endfunction

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_result(output int lat);
        lat = 1;
        tick();
        while (!out_valid && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_job(input string tag, input logic md, input int e[9],
                           input longint exp_det, input longint exp_ovf, input int exp_lat);
        int lat;
        mode      = md;
        mat       = pack(e);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, " in_ready before accept"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        mat      = {9{8'h55}};
        mode     = ~md;
        check({tag, " in_ready after accept"}, in_ready, 0);
        wait_result(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " det"}, $signed(det), exp_det);
        check({tag, " ovf"}, ovf, exp_ovf);
        tick();
        check({tag, " out_valid pulse"}, out_valid, 0);
        check({tag, " in_ready after handoff"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; mode = 1'b0; mat = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", out_valid, 0);
        check("reset det", $signed(det), 0);
        check("reset ovf", ovf, 0);
        check("reset in_ready", in_ready, 1);

        run_job("2x2 basic", 1'b0, '{3, 4, 127, 2, 5, 127, 127, 127, 127}, 7, 0, 3);
        run_job("3x3 basic", 1'b1, '{2, -3, 1, 2, 0, -1, 1, 4, 5}, 49, 0, 10);
        run_job("sat pos", 1'b1, '{127, -128, 0, 127, 127, 0, 0, 0, 127}, 32767, 1, 10);
        run_job("sat neg", 1'b1, '{127, 127, 0, 127, -128, 0, 0, 0, 127}, -32768, 1, 10);

        // Backpressure with in_valid held high throughout.
        mode = 1'b0; mat = pack('{-128, -128, 0, 127, -128, 0, 0, 0, 0});
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        wait_result(lat);
        check("bp latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid held", out_valid, 1);
            check("bp det held", $signed(det), 32640);
            check("bp ovf held", ovf, 0);
            check("bp in_ready low", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp handoff out_valid", out_valid, 0);
        check("bp handoff in_ready", in_ready, 1);
        mat = pack('{1, 2, 0, 3, 4, 0, 0, 0, 0});
        tick();
        in_valid = 1'b0;
        check("bp second accepted", in_ready, 0);
        wait_result(lat);
        check("bp second latency", lat, 2 + 1);
        check("bp second det", $signed(det), -2);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp no queued request", out_valid, 0);
            tick();
        end

        // Reset at step 4 of a 3x3 job.
        mode = 1'b1; mat = pack('{2, -3, 1, 2, 0, -1, 1, 4, 5});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst det", $signed(det), 0);
        check("midrst ovf", ovf, 0);
        check("midrst in_ready", in_ready, 1);
        run_job("post reset 2x2", 1'b0, '{3, 4, 0, 2, 5, 0, 0, 0, 0}, 7, 0, 3);

        // Back-to-back: second request offered continuously.
        mode = 1'b1; mat = pack('{2, -3, 1, 2, 0, -1, 1, 4, 5});
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        mode = 1'b0; mat = pack('{1, 2, 0, 3, 4, 0, 0, 0, 0});
        wait_result(lat);
        check("b2b first latency", lat, 10);
        check("b2b first det", $signed(det), 49);
        tick();
        check("b2b idle after handoff", in_ready, 1);
        check("b2b out_valid after handoff", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("b2b second accepted", in_ready, 0);
        wait_result(lat);
        check("b2b second latency", lat, 3);
        check("b2b second det", $signed(det), -2);
        check("b2b second ovf", ovf, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
